// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and constants for the four-master round-robin bus arbiter.
// Active-low strobes use ENABLE_/DISABLE_; active-high flags use ENABLE/DISABLE.
package bus_arbiter_rr_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;

  localparam int NUM_MASTERS = 4;
  localparam int BUS_OWNER_W = 2;

  typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_M0 = 2'd0;
  localparam bus_owner_t BUS_OWNER_M1 = 2'd1;
  localparam bus_owner_t BUS_OWNER_M2 = 2'd2;
  localparam bus_owner_t BUS_OWNER_M3 = 2'd3;

  // One-hot-low grant vector for a given owner.
  function automatic logic [NUM_MASTERS-1:0] grant_decode(input bus_owner_t owner);
    logic [NUM_MASTERS-1:0] grnt_n;
    grnt_n = {NUM_MASTERS{DISABLE_}};
    grnt_n[owner] = ENABLE_;
    return grnt_n;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotate-scan: finds the first requester after the current owner,
// looking at owner+1, owner+2, owner+3 (mod 4). The owner itself is never picked.
module bus_arb_rr_pick
  import bus_arbiter_rr_pkg::*;
(
  input  logic [1:0] owner,
  input  logic [3:0] req_n,
  output logic [1:0] next_owner,
  output logic       found
);

  logic [1:0] cand [1:3];

  genvar gi;
  generate
    for (gi = 1; gi < NUM_MASTERS; gi++) begin : g_cand
      assign cand[gi] = owner + 2'(gi);
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest requester overrides.
  always_comb begin
    next_owner = owner;
    found      = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
      if (req_n[cand[k]] == ENABLE_) begin
        next_owner = cand[k];
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for four bus masters with a hold limit that preempts a
// long-running owner, but only between transfers.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_n,
  input  logic       m1_req_n,
  input  logic       m2_req_n,
  input  logic       m3_req_n,
  output logic       m0_grnt_n,
  output logic       m1_grnt_n,
  output logic       m2_grnt_n,
  output logic       m3_grnt_n,
  input  logic       m_as_n,
  input  logic       m_rdy_n,
  output logic [1:0] bus_owner
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  logic [3:0]       req_n;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             in_flight_q, in_flight_d;

  logic [1:0] pick_owner;
  logic       pick_found;
  logic       owner_req;
  logic       handoff;
  logic       preempt;
  logic [3:0] grnt_n;

  assign req_n = {m3_req_n, m2_req_n, m1_req_n, m0_req_n};

  bus_arb_rr_pick u_pick (
    .owner      (owner_q),
    .req_n      (req_n),
    .next_owner (pick_owner),
    .found      (pick_found)
  );

  always_comb begin
    owner_d     = owner_q;
    hold_cnt_d  = hold_cnt_q;
    in_flight_d = in_flight_q;
    owner_req   = (req_n[owner_q] == ENABLE_);
    handoff     = !owner_req && pick_found;
    preempt     = owner_req && (hold_cnt_q == HOLD_LIMIT) && pick_found
                  && (m_as_n == DISABLE_);

    // A wait-stated transfer pins ownership until the slave answers.
    if (!in_flight_q && (handoff || preempt)) begin
      owner_d = pick_owner;
    end

    if ((owner_d != owner_q) || !owner_req) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q < HOLD_LIMIT) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    if (m_rdy_n == ENABLE_) begin
      in_flight_d = DISABLE;
    end else if (m_as_n == ENABLE_) begin
      in_flight_d = ENABLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= BUS_OWNER_M0;
      hold_cnt_q  <= '0;
      in_flight_q <= DISABLE;
    end else begin
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign grnt_n    = grant_decode(owner_q);
  assign m0_grnt_n = grnt_n[0];
  assign m1_grnt_n = grnt_n[1];
  assign m2_grnt_n = grnt_n[2];
  assign m3_grnt_n = grnt_n[3];
  assign bus_owner = owner_q;

endmodule
